pb_sample_feeder: RTL and testbench
===================================

# pb_sample_feeder

Rate-paced byte feeder sitting directly upstream of the PicoBlaze I/O wrapper. Accepts bytes from a valid/ready producer (flash/audio reader) into a small FIFO. Every `PERIOD_CYCLES` clocks it pops one byte into a held output register, which drives the wrapper's `input_data` (read at port 0x00). It then pulses an interrupt line that drives the wrapper's `interrupt_flag`. FIFO starvation is flagged as underrun instead of producing a stale interrupt.

## Interface
- `PERIOD_CYCLES`, default 2500: clocks per sample tick (10 kHz at 25 MHz); legal range 4..2^24.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two, 2..16.
- `IRQ_CYCLES`, default 4: width of each `sample_irq` pulse in clocks; legal range 2..`PERIOD_CYCLES`-1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; when high, the tick counter runs.
- `in_data`  in  8  producer byte.
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_ready`  out  1  FIFO can accept; equals `fifo_level != FIFO_DEPTH`.
- `sample_data`  out  8  registered current sample; connects to `input_data` of the PicoBlaze wrapper.
- `sample_irq`  out  1  registered interrupt pulse; connects to `interrupt_flag`.
- `clear_underrun`  in  1  synchronous clear of `underrun` and `underrun_count`.
- `underrun`  out  1  sticky: a tick found the FIFO empty.
- `underrun_count`  out  8  number of empty ticks, saturating at 255.
- `fifo_level`  out  clog2(`FIFO_DEPTH`)+1  current FIFO occupancy.

## Operation
- Reset (asynchronous, immediate) sets the following; `in_ready` therefore reads 1 during and after reset.
  - `sample_data` = 0x00, `sample_irq` = 0, `underrun` = 0, `underrun_count` = 0, `fifo_level` = 0.
  - Tick counter = 0, irq counter = 0, FIFO pointers = 0.
- Push: when `in_valid && in_ready`, `in_data` is written at the tail and the write pointer wraps modulo `FIFO_DEPTH`.
- Tick counter:
  - While `enable` is high, it counts 0..`PERIOD_CYCLES`-1 and wraps.
  - `tick` is asserted for the one cycle in which the counter equals `PERIOD_CYCLES`-1.
  - While `enable` is low, the counter is forced to 0 and there are no ticks.
- On `tick`, the FIFO is non-empty, so:
  - `sample_data` <= head, the read pointer advances, and the irq counter loads `IRQ_CYCLES`.
- On `tick`, the FIFO is empty, so:
  - `sample_data` holds its value and no irq is generated.
  - `underrun` <= 1; `underrun_count` increments unless it is already 255.
- `sample_irq` = (irq counter != 0), registered. The counter decrements each cycle down to 0.
  - Deasserting `enable` does not truncate a pulse already in progress.
- Simultaneous push and pop: `fifo_level` is unchanged and both pointers advance.
  - `in_ready` is computed from the pre-edge level, so a full FIFO rejects a push even on a pop cycle.
- `clear_underrun` together with an empty tick in the same cycle: the clear wins, and both flags end at 0.
- FIFO storage is not reset-initialised. Only the pointers and level reset.

## Timing
- A byte pushed into an empty FIFO at edge t is at the head from t+1 and is eligible for the first tick at or after t+1.
- Tick at cycle n:
  - `sample_data` updates at edge n+1.
  - `sample_irq` is high for cycles n+1..n+`IRQ_CYCLES`.
- The data is stable before and throughout the irq pulse, and it stays stable until the next tick, so the ISR's `INPUT` from port 0x00 always reads the new byte.
- After `enable` rises, the first tick occurs `PERIOD_CYCLES`-1 cycles later, at counter value `PERIOD_CYCLES`-1.
- Tick spacing is exactly `PERIOD_CYCLES` with no drift. Push traffic and underruns never stretch it.
- `in_ready` is combinational from `fifo_level` only. There is no combinational path from `in_valid`.
- Asserting `reset` mid-pulse drops `sample_irq` immediately (asynchronously). Bytes in flight are discarded.

## Test plan
Parameters for all scenarios: `PERIOD_CYCLES`=8, `FIFO_DEPTH`=4, `IRQ_CYCLES`=2.

- Basic feed: push 0xA5 with `enable` high.
  - At the first tick, `sample_data` = 0xA5 from the next edge.
  - `sample_irq` is high for exactly 2 cycles, then low.
  - `fifo_level` goes 1 -> 0.
- Full FIFO: push 0x01..0x06 continuously.
  - `in_ready` drops after 4 accepted bytes; 0x05 waits.
  - Successive ticks 8 cycles apart output 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 in order.
  - Pointers wrap with no loss or duplication.
- Underrun: no pushes, 3 ticks.
  - `sample_irq` stays 0 and `sample_data` holds 0x00.
  - `underrun` = 1 and `underrun_count` = 3.
  - Pulse `clear_underrun` -> both read 0.
  - Run 260 empty ticks -> `underrun_count` saturates at 255.
- Simultaneous push/pop: hold `fifo_level` = 2 and push on the tick cycle.
  - Level stays 2 and the head byte is output.
  - Also, at level 4 with push on the tick cycle: the push is rejected and level becomes 3.
- Enable gating: drop `enable` at counter value 5.
  - No tick occurs. After re-enable, the tick comes exactly 7 cycles later.
  - Drop `enable` during an irq pulse -> the pulse still lasts 2 cycles.
- Async reset mid-operation: assert `reset` during an irq pulse with 3 bytes queued.
  - `sample_irq`, `sample_data`, and `fifo_level` go to 0 immediately, without a clock edge.
  - `in_ready` = 1.
  - After release, the first tick is 7 cycles after the first enabled cycle.

Source files
------------

// File: rtl/pb_sample_feeder.sv
// Rate-paced byte feeder: a small FIFO drained one byte per sample tick into a held
// output register, with an interrupt pulse per delivered byte and underrun tracking.
module pb_sample_feeder #(
    parameter int PERIOD_CYCLES = 2500,
    parameter int FIFO_DEPTH    = 4,
    parameter int IRQ_CYCLES    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    sample_data,
    output logic                          sample_irq,
    input  logic                          clear_underrun,
    output logic                          underrun,
    output logic [7:0]                    underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam int IW = $clog2(IRQ_CYCLES + 1);

    logic [7:0]    mem [FIFO_DEPTH];

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [IW-1:0] irq_cnt_q, irq_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    sample_q, sample_d;
    logic          irq_q, irq_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    ucount_q, ucount_d;

    logic tick;
    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (level_q == '0);
    assign in_ready   = (level_q != LW'(FIFO_DEPTH));
    assign tick       = enable && (tick_cnt_q == CW'(PERIOD_CYCLES - 1));
    assign push       = in_valid && in_ready;
    assign pop        = tick && !fifo_empty;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        irq_cnt_d  = irq_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sample_d   = sample_q;
        underrun_d = underrun_q;
        ucount_d   = ucount_q;

        if (!enable || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            sample_d = mem[rd_ptr_q];
        end
        level_d = level_q + LW'(push) - LW'(pop);

        if (pop) begin
            irq_cnt_d = IW'(IRQ_CYCLES);
        end else if (irq_cnt_q != '0) begin
            irq_cnt_d = irq_cnt_q - IW'(1);
        end
        irq_d = (irq_cnt_d != '0);

        // The clear takes priority over an empty tick arriving in the same cycle.
        if (clear_underrun) begin
            underrun_d = 1'b0;
            ucount_d   = '0;
        end else if (tick && fifo_empty) begin
            underrun_d = 1'b1;
            if (ucount_q != 8'hFF) begin
                ucount_d = ucount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            irq_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            irq_q      <= 1'b0;
            underrun_q <= 1'b0;
            ucount_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            irq_cnt_q  <= irq_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            irq_q      <= irq_d;
            underrun_q <= underrun_d;
            ucount_q   <= ucount_d;
        end
    end

    // Storage carries no reset so it can map onto plain distributed memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign sample_data    = sample_q;
    assign sample_irq     = irq_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucount_q;
    assign fifo_level     = level_q;
endmodule

// File: tb/tb_pb_sample_feeder.sv
// Randomized and directed stimulus for pb_sample_feeder, checked each cycle against a
// queue-based model of the sample stream, tick schedule and underrun bookkeeping.
module tb_pb_sample_feeder;
    localparam int PERIOD = 8;
    localparam int DEPTH  = 4;
    localparam int IRQ    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] sample_data;
    logic       sample_irq;
    logic       clear_underrun = 1'b0;
    logic       underrun;
    logic [7:0] underrun_count;
    logic [2:0] fifo_level;

    pb_sample_feeder #(
        .PERIOD_CYCLES(PERIOD),
        .FIFO_DEPTH   (DEPTH),
        .IRQ_CYCLES   (IRQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sample_data   (sample_data),
        .sample_irq    (sample_irq),
        .clear_underrun(clear_underrun),
        .underrun      (underrun),
        .underrun_count(underrun_count),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_sample;
    logic       m_under;
    int         m_ucnt;
    int         en_run;
    int         cyc;
    int         last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sample = 8'h00;
        m_under  = 1'b0;
        m_ucnt   = 0;
        en_run   = 0;
        last_pop = -1000;
    endtask

    task automatic check_outputs();
        check("sample_data", {24'h0, sample_data}, {24'h0, m_sample});
        check("sample_irq", {31'h0, sample_irq}, {31'h0, (cyc - last_pop) < IRQ});
        check("fifo_level", {29'h0, fifo_level}, m_q.size());
        check("underrun", {31'h0, underrun}, {31'h0, m_under});
        check("underrun_count", {24'h0, underrun_count}, m_ucnt);
    endtask

    // One clock of stimulus followed by a model update and full comparison.
    task automatic step(input logic en, input logic v, input logic [7:0] d, input logic clr);
        int  pre;
        bit  tick;
        enable         = en;
        in_valid       = v;
        in_data        = d;
        clear_underrun = clr;
        check("in_ready", {31'h0, in_ready}, {31'h0, m_q.size() != DEPTH});
        @(posedge clk);
        #1;
        cyc++;
        pre  = m_q.size();
        // A tick is the last cycle of every PERIOD-long stretch of continuous enable.
        tick = en && ((en_run % PERIOD) == PERIOD - 1);
        en_run = en ? en_run + 1 : 0;
        if (tick && pre > 0) begin
            m_sample = m_q.pop_front();
            last_pop = cyc;
            $display("cycle %0d: sample 0x%02h delivered, level %0d", cyc, m_sample, m_q.size());
        end
        if (v && pre != DEPTH) m_q.push_back(d);
        if (clr) begin
            m_under = 1'b0;
            m_ucnt  = 0;
        end else if (tick && pre == 0) begin
            m_under = 1'b1;
            if (m_ucnt < 255) m_ucnt++;
        end
        check_outputs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] next_byte;
        int         waited;
        cyc = 0;
        model_reset();

        // Reset state, before any clock edge
        #1;
        check("rst_sample", {24'h0, sample_data}, 32'h0);
        check("rst_irq", {31'h0, sample_irq}, 32'h0);
        check("rst_level", {29'h0, fifo_level}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        apply_reset();

        // Underrun: three empty ticks, clear, then saturation
        for (int i = 0; i < 3 * PERIOD; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("underrun3_cnt", {24'h0, underrun_count}, 32'd3);
        check("underrun3_flag", {31'h0, underrun}, 32'h1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("clear_cnt", {24'h0, underrun_count}, 32'd0);
        for (int i = 0; i < 260 * PERIOD; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("saturate_cnt", {24'h0, underrun_count}, 32'd255);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Basic feed
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 2 * PERIOD; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        check("basic_sample", {24'h0, sample_data}, 32'hA5);

        // Full FIFO: stream 0x01..0x06 through a depth-4 buffer
        next_byte = 8'h01;
        for (int i = 0; i < 8 * PERIOD; i++) begin
            if (next_byte <= 8'h06) begin
                if (m_q.size() != DEPTH) begin
                    step(1'b1, 1'b1, next_byte, 1'b0);
                    next_byte++;
                end else begin
                    step(1'b1, 1'b1, next_byte, 1'b0);
                end
            end else begin
                step(1'b1, 1'b0, 8'h00, 1'b0);
            end
        end
        check("full_last", {24'h0, sample_data}, 32'h06);

        // Randomized traffic, enable gating and underrun clears
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0,
                 8'($urandom), $urandom_range(0, 40) == 0);
        end

        // Async reset during an irq pulse with three bytes queued
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
        waited = 0;
        while (!sample_irq && waited < 4 * PERIOD) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            waited++;
        end
        check("irq_seen", {31'h0, sample_irq}, 32'h1);
        check("queued3", {29'h0, fifo_level}, 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("async_irq", {31'h0, sample_irq}, 32'h0);
        check("async_sample", {24'h0, sample_data}, 32'h0);
        check("async_level", {29'h0, fifo_level}, 32'h0);
        check("async_in_ready", {31'h0, in_ready}, 32'h1);
        enable = 1'b0;
        apply_reset();

        // First tick after release lands on the eighth enabled cycle
        step(1'b1, 1'b1, 8'h77, 1'b0);
        waited = 1;
        while (!sample_irq && waited < 4 * PERIOD) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            waited++;
        end
        check("first_tick_delay", waited, PERIOD);
        check("post_reset_sample", {24'h0, sample_data}, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
